// File: rtl/core_feeder.sv
// Packs a host element stream into pr-lane words, writes them row by row into the
// core memory, then sequences one read/execute instruction per buffered row.
`timescale 1ns/1ps
module core_feeder #(
  parameter int unsigned bw    = 8,
  parameter int unsigned pr    = 8,
  parameter int unsigned depth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [bw-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                start_exec,
  output logic [pr*bw-1:0]    mem_in,
  output logic [16:0]         inst,
  output logic                busy,
  output logic                done
);

  localparam int unsigned lw = (pr > 1) ? $clog2(pr) : 1;
  localparam int unsigned rw = $clog2(depth) + 1;
  localparam logic [rw-1:0] depth_c = rw'(depth);

  typedef enum logic [1:0] {PACK, WRITE, EXEC, DONE} state_t;

  state_t            state;
  logic [lw-1:0]     lane_cnt;
  logic [rw-1:0]     row_cnt;
  logic [rw-1:0]     exec_cnt;
  logic [pr*bw-1:0]  pack;
  logic              pending;

  logic              accept;
  logic              last_lane;
  logic              lane_any;
  logic [pr*bw-1:0]  pack_n;

  // {zero, execute, read, write, address}
  function automatic logic [16:0] mk_inst(input logic [3:0] addr, input logic wr,
                                          input logic rd, input logic ex);
    return {10'd0, ex, rd, wr, addr};
  endfunction

  // Current row word including the element accepted this cycle
  always_comb begin
    accept    = in_valid && in_ready && (state == PACK);
    last_lane = accept && (lane_cnt == lw'(pr - 1));
    lane_any  = accept || (lane_cnt != '0);
    pack_n    = pack;
    for (int unsigned l = 0; l < pr; l++) begin
      if (accept && (lane_cnt == lw'(l))) pack_n[l*bw +: bw] = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PACK;
      lane_cnt <= '0;
      row_cnt  <= '0;
      exec_cnt <= '0;
      pack     <= '0;
      pending  <= 1'b0;
      mem_in   <= '0;
      inst     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        PACK: begin
          if (accept) begin
            lane_cnt <= lane_cnt + lw'(1);
            pack     <= pack_n;
          end
          // Unfilled lanes are already zero because pack is cleared after every write
          if (last_lane || (start_exec && lane_any)) begin
            state    <= WRITE;
            mem_in   <= pack_n;
            pack     <= '0;
            lane_cnt <= '0;
            pending  <= start_exec;
            inst     <= mk_inst(4'(row_cnt), 1'b1, 1'b0, 1'b0);
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end else if (start_exec) begin
            busy     <= 1'b1;
            in_ready <= 1'b0;
            exec_cnt <= '0;
            if (row_cnt != '0) begin
              state <= EXEC;
              inst  <= mk_inst(4'd0, 1'b0, 1'b1, 1'b1);
            end else begin
              state <= DONE;
              inst  <= '0;
              done  <= 1'b1;
            end
          end else begin
            in_ready <= (row_cnt < depth_c);
          end
        end
        WRITE: begin
          row_cnt <= row_cnt + rw'(1);
          if (pending) begin
            pending  <= 1'b0;
            state    <= EXEC;
            exec_cnt <= '0;
            inst     <= mk_inst(4'd0, 1'b0, 1'b1, 1'b1);
          end else begin
            state    <= PACK;
            inst     <= '0;
            busy     <= 1'b0;
            in_ready <= ((row_cnt + rw'(1)) < depth_c);
          end
        end
        EXEC: begin
          if (exec_cnt == (row_cnt - rw'(1))) begin
            state <= DONE;
            inst  <= '0;
            done  <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt + rw'(1);
            inst     <= mk_inst(4'(exec_cnt + rw'(1)), 1'b0, 1'b1, 1'b1);
          end
        end
        DONE: begin
          state    <= PACK;
          row_cnt  <= '0;
          exec_cnt <= '0;
          lane_cnt <= '0;
          pack     <= '0;
          pending  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state <= PACK;
          inst  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_feeder.sv
// Bench for core_feeder: transaction-level model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_core_feeder;

  localparam int unsigned BW    = 8;
  localparam int unsigned PR    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MW    = PR * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          start_exec = 1'b0;
  logic [MW-1:0] mem_in;
  logic [16:0]   inst;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  core_feeder #(.bw(BW), .pr(PR), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start_exec(start_exec), .mem_in(mem_in),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: rows of elements and a plan of future busy cycles
  typedef struct {
    logic [16:0]   inst;
    logic          done;
    logic          wr;
    logic [MW-1:0] word;
  } ent_t;

  logic [BW-1:0] elems[$];
  ent_t          plan[$];
  int            rows = 0;
  logic [16:0]   c_inst = '0;
  logic          c_busy = 1'b0;
  logic          c_done = 1'b0;
  logic          c_ready = 1'b0;
  logic [MW-1:0] c_word = '0;

  always @(posedge clk or posedge reset) begin
    ent_t e;
    logic [MW-1:0] w;
    if (reset) begin
      elems.delete();
      plan.delete();
      rows = 0;
      c_inst = '0; c_busy = 1'b0; c_done = 1'b0; c_ready = 1'b0; c_word = '0;
    end else begin
      if (!c_busy) begin
        if (in_valid && c_ready) elems.push_back(in_data);
        if (elems.size() == PR || (start_exec && elems.size() > 0)) begin
          w = '0;
          foreach (elems[i]) w[i*BW +: BW] = elems[i];
          elems.delete();
          e.inst = 17'h010 | 17'(rows); e.done = 1'b0; e.wr = 1'b1; e.word = w;
          plan.push_back(e);
          rows++;
        end
        if (start_exec) begin
          for (int a = 0; a < rows; a++) begin
            e.inst = 17'h060 | 17'(a); e.done = 1'b0; e.wr = 1'b0; e.word = '0;
            plan.push_back(e);
          end
          e.inst = '0; e.done = 1'b1; e.wr = 1'b0; e.word = '0;
          plan.push_back(e);
          rows = 0;
        end
      end
      if (plan.size() > 0) begin
        e = plan.pop_front();
        c_inst = e.inst; c_busy = 1'b1; c_done = e.done; c_ready = 1'b0;
        if (e.wr) c_word = e.word;
      end else begin
        c_inst = '0; c_busy = 1'b0; c_done = 1'b0; c_ready = (rows < DEPTH);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_inst", 64'(inst), 64'(c_inst));
    chk("m_busy", 64'(busy), 64'(c_busy));
    chk("m_done", 64'(done), 64'(c_done));
    chk("m_ready", 64'(in_ready), 64'(c_ready));
    chk("m_mem_in", 64'(mem_in), 64'(c_word));
  end

  // ---------------- stimulus helpers (entered and left right after a negedge)
  task automatic send(input logic [BW-1:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start_exec = 1'b1;
    @(negedge clk);
    start_exec = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_mem", 64'(mem_in), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // one streamed row
    for (int i = 1; i <= 8; i++) send(BW'(i));
    chk("t1_inst", 64'(inst), 64'h010);
    chk("t1_mem", 64'(mem_in), 64'h0807060504030201);
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_inst_idle", 64'(inst), 64'd0);
    chk("t1_mem_hold", 64'(mem_in), 64'h0807060504030201);

    // three rows then execute
    for (int r = 1; r <= 2; r++)
      for (int l = 0; l < 8; l++) send(BW'(r * 16 + l));
    chk("t2_write_addr", 64'(inst), 64'h012);
    @(negedge clk);
    pulse_start();
    for (int a = 0; a < 3; a++) begin
      chk("t2_exec", 64'(inst), 64'h060 + 64'(a));
      @(negedge clk);
    end
    chk("t2_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("t2_done_pulse", 64'(done), 64'd0);
    chk("t2_busy_low", 64'(busy), 64'd0);

    // execute with nothing buffered
    pulse_start();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_inst", 64'(inst), 64'd0);
    @(negedge clk);
    chk("t3_busy_low", 64'(busy), 64'd0);

    // partial row flushed by start_exec
    for (int i = 0; i < 5; i++) send(8'hAA);
    pulse_start();
    chk("t4_mem", 64'(mem_in), 64'h000000AAAAAAAAAA);
    chk("t4_inst", 64'(inst), 64'h010);
    @(negedge clk);
    chk("t4_exec", 64'(inst), 64'h060);
    @(negedge clk);
    chk("t4_done", 64'(done), 64'd1);
    @(negedge clk);

    // fill all rows, then keep offering data
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 8; l++) send(BW'(r * 8 + l));
    chk("t5_last_inst", 64'(inst), 64'h01F);
    chk("t5_last_word", 64'(mem_in), 64'h7F7E7D7C7B7A7978);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (4) begin
      @(negedge clk);
      chk("t5_full_ready", 64'(in_ready), 64'd0);
      chk("t5_no_write", 64'(inst), 64'd0);
    end
    in_valid = 1'b0;
    pulse_start();
    for (int a = 0; a < 16; a++) begin
      chk("t5_exec", 64'(inst), 64'h060 + 64'(a));
      @(negedge clk);
    end
    chk("t5_done", 64'(done), 64'd1);
    @(negedge clk);

    // reset during the second execute cycle
    for (int i = 0; i < 16; i++) send(BW'(8'h40 + i));
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("t6_exec2", 64'(inst), 64'h061);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_inst", 64'(inst), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_mem", 64'(mem_in), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send(BW'(8'h11 * (i + 1)));
    chk("t6_addr0", 64'(inst), 64'h010);
    chk("t6_mem", 64'(mem_in), 64'h8877665544332211);

    // start_exec coinciding with the element that completes a row
    for (int i = 0; i < 7; i++) send(BW'(8'h90 + i));
    in_valid   = 1'b1;
    in_data    = 8'h99;
    start_exec = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    start_exec = 1'b0;
    chk("t7_write", 64'(inst), 64'h011);
    chk("t7_mem", 64'(mem_in), 64'h9996959493929190);
    @(negedge clk);
    chk("t7_exec0", 64'(inst), 64'h060);
    @(negedge clk);
    chk("t7_exec1", 64'(inst), 64'h061);
    @(negedge clk);
    chk("t7_done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
